// File: rtl/mem_bus_arbiter.sv
// Purpose : shares one core-side memory port between instruction fetch (IF) and load/store (LSU).
// Latency : grant one cycle after request; owner ack is combinational with mem_ack_i; one IDLE cycle between transactions.
// Backpressure: single outstanding transaction; requesters hold req until ack or flush, mem_* held stable until mem_ack_i or timeout.
//
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   if_req_i/if_addr_i/if_flush_i     IF request side;  if_ack_o/if_rdata_o   IF completion
//   lsu_req_i/lsu_w_en_i/lsu_addr_i/
//   lsu_wdata_i/lsu_sel_i/lsu_flush_i LSU request side; lsu_ack_o/lsu_rdata_o LSU completion
//   mem_req_o/mem_w_en_o/mem_addr_o/
//   mem_wdata_o/mem_sel_o             registered shared-port request; mem_ack_i/mem_rdata_i completion
//   bus_err_o                         one-cycle pulse when a transaction times out
//   grant_o                           current owner: 00 none, 01 IF, 10 LSU
module mem_bus_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT_CYC  = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    input  logic                if_flush_i,
    output logic                if_ack_o,
    output logic [DATA_W-1:0]   if_rdata_o,
    input  logic                lsu_req_i,
    input  logic                lsu_w_en_i,
    input  logic [ADDR_W-1:0]   lsu_addr_i,
    input  logic [DATA_W-1:0]   lsu_wdata_i,
    input  logic [DATA_W/8-1:0] lsu_sel_i,
    input  logic                lsu_flush_i,
    output logic                lsu_ack_o,
    output logic [DATA_W-1:0]   lsu_rdata_o,
    output logic                mem_req_o,
    output logic                mem_w_en_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_sel_o,
    input  logic                mem_ack_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    output logic                bus_err_o,
    output logic [1:0]          grant_o
);

    localparam int SEL_W = DATA_W / 8;
    localparam logic [3:0] STREAK_MAX = 4'(STARVE_LIMIT);
    // The counter value seen during the last permitted busy cycle.
    localparam logic [7:0] TMO_LAST = 8'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        IF_BUSY  = 2'b01,
        LSU_BUSY = 2'b10
    } state_t;

    state_t      state_q, state_d;
    logic        if_elig, lsu_elig;
    logic        grant_if, grant_lsu;
    logic        busy;
    logic        tmo_hit;
    logic        finish;
    logic        owner_flush;
    logic        drop_q;
    logic [3:0]  streak_q;
    logic [7:0]  tmo_cnt_q;

    assign if_elig  = if_req_i  & ~if_flush_i;
    assign lsu_elig = lsu_req_i & ~lsu_flush_i;
    assign busy     = (state_q != IDLE);

    // A real ack in the same cycle wins over the timeout, so no error is raised then.
    assign tmo_hit = (TIMEOUT_CYC != 0) && busy && !mem_ack_i && (tmo_cnt_q == TMO_LAST);
    assign finish  = busy && (mem_ack_i || tmo_hit);

    assign owner_flush = ((state_q == IF_BUSY)  && if_flush_i) ||
                         ((state_q == LSU_BUSY) && lsu_flush_i);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and arbitration
    always_comb begin
        state_d   = state_q;
        grant_if  = 1'b0;
        grant_lsu = 1'b0;
        case (state_q)
            IDLE: begin
                // LSU has priority unless IF has already been passed over STARVE_LIMIT times.
                grant_lsu = lsu_elig && !(if_elig && (streak_q == STREAK_MAX));
                grant_if  = if_elig && !grant_lsu;
                if (grant_lsu) begin
                    state_d = LSU_BUSY;
                end else if (grant_if) begin
                    state_d = IF_BUSY;
                end
            end
            IF_BUSY, LSU_BUSY: begin
                if (finish) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: acks are suppressed when the owner flushed earlier (drop) or is flushing now.
    always_comb begin
        if_ack_o    = 1'b0;
        if_rdata_o  = '0;
        lsu_ack_o   = 1'b0;
        lsu_rdata_o = '0;
        grant_o     = 2'b00;
        bus_err_o   = tmo_hit;
        case (state_q)
            IF_BUSY: begin
                grant_o = 2'b01;
                if (finish && !drop_q && !if_flush_i) begin
                    if_ack_o   = 1'b1;
                    if_rdata_o = mem_ack_i ? mem_rdata_i : '0;
                end
            end
            LSU_BUSY: begin
                grant_o = 2'b10;
                if (finish && !drop_q && !lsu_flush_i) begin
                    lsu_ack_o   = 1'b1;
                    lsu_rdata_o = mem_ack_i ? mem_rdata_i : '0;
                end
            end
            default: ;
        endcase
    end

    // Shared-port request registers, captured on the grant edge and cleared on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req_o   <= 1'b0;
            mem_w_en_o  <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_sel_o   <= '0;
        end else if (grant_lsu) begin
            mem_req_o   <= 1'b1;
            mem_w_en_o  <= lsu_w_en_i;
            mem_addr_o  <= lsu_addr_i;
            mem_wdata_o <= lsu_wdata_i;
            mem_sel_o   <= lsu_sel_i;
        end else if (grant_if) begin
            mem_req_o   <= 1'b1;
            mem_w_en_o  <= 1'b0;
            mem_addr_o  <= if_addr_i;
            mem_wdata_o <= '0;
            mem_sel_o   <= {SEL_W{1'b1}};
        end else if (finish) begin
            mem_req_o   <= 1'b0;
            mem_w_en_o  <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_sel_o   <= '0;
        end
    end

    // Drop flag, timeout counter and IF starvation streak.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q    <= 1'b0;
            tmo_cnt_q <= '0;
            streak_q  <= '0;
        end else begin
            if (grant_if || grant_lsu || finish) begin
                drop_q <= 1'b0;
            end else if (owner_flush) begin
                drop_q <= 1'b1;
            end

            if (grant_if || grant_lsu) begin
                tmo_cnt_q <= '0;
            end else if ((TIMEOUT_CYC != 0) && busy && !mem_ack_i) begin
                tmo_cnt_q <= tmo_cnt_q + 8'd1;
            end

            if (!if_elig || grant_if) begin
                streak_q <= '0;
            end else if (grant_lsu && (streak_q != STREAK_MAX)) begin
                streak_q <= streak_q + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Purpose : self-checking bench for mem_bus_arbiter (STARVE_LIMIT=4, TIMEOUT_CYC=8).
// Latency : inputs driven just after the falling edge, outputs sampled 1 time unit later.
// Backpressure: memory acks are driven directly by the bench; every wait is bounded.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, if_flush, lsu_req, lsu_w_en, lsu_flush, mem_ack;
    logic [31:0] if_addr, lsu_addr, lsu_wdata, mem_rdata;
    logic [3:0]  lsu_sel;
    logic        if_ack_o, lsu_ack_o, mem_req_o, mem_w_en_o, bus_err_o;
    logic [31:0] if_rdata_o, lsu_rdata_o, mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_sel_o;
    logic [1:0]  grant_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4), .TIMEOUT_CYC(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_flush_i(if_flush),
        .if_ack_o(if_ack_o), .if_rdata_o(if_rdata_o),
        .lsu_req_i(lsu_req), .lsu_w_en_i(lsu_w_en), .lsu_addr_i(lsu_addr),
        .lsu_wdata_i(lsu_wdata), .lsu_sel_i(lsu_sel), .lsu_flush_i(lsu_flush),
        .lsu_ack_o(lsu_ack_o), .lsu_rdata_o(lsu_rdata_o),
        .mem_req_o(mem_req_o), .mem_w_en_o(mem_w_en_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_sel_o(mem_sel_o),
        .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata),
        .bus_err_o(bus_err_o), .grant_o(grant_o)
    );

    typedef struct packed {
        logic        if_req;
        logic [31:0] if_addr;
        logic        if_flush;
        logic        lsu_req;
        logic        lsu_w_en;
        logic [31:0] lsu_addr;
        logic [31:0] lsu_wdata;
        logic [3:0]  lsu_sel;
        logic        lsu_flush;
        logic        mem_ack;
        logic [31:0] mem_rdata;
    } vin_t;

    typedef struct packed {
        logic        if_ack;
        logic [31:0] if_rdata;
        logic        lsu_ack;
        logic [31:0] lsu_rdata;
        logic        mem_req;
        logic        mem_w_en;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_sel;
        logic        bus_err;
        logic [1:0]  grant;
    } vout_t;

    typedef struct packed {
        vin_t  vi;
        vout_t vo;
    } vec_t;

    localparam int NVEC = 16;
    vec_t tbl [NVEC];

    function automatic vin_t mk_in(logic ir, logic [31:0] ia, logic ifl,
                                   logic lr, logic lw, logic [31:0] la, logic [31:0] lwd,
                                   logic [3:0] ls, logic lfl, logic ma, logic [31:0] mrd);
        vin_t v;
        v = '{ir, ia, ifl, lr, lw, la, lwd, ls, lfl, ma, mrd};
        return v;
    endfunction

    function automatic vout_t mk_out(logic ia, logic [31:0] ird, logic la, logic [31:0] lrd,
                                     logic mr, logic mw, logic [31:0] mad, logic [31:0] mwd,
                                     logic [3:0] ms, logic be, logic [1:0] g);
        vout_t v;
        v = '{ia, ird, la, lrd, mr, mw, mad, mwd, ms, be, g};
        return v;
    endfunction

    function automatic vout_t sample();
        vout_t v;
        v = '{if_ack_o, if_rdata_o, lsu_ack_o, lsu_rdata_o, mem_req_o, mem_w_en_o,
              mem_addr_o, mem_wdata_o, mem_sel_o, bus_err_o, grant_o};
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        if_req = 0; if_addr = 0; if_flush = 0;
        lsu_req = 0; lsu_w_en = 0; lsu_addr = 0; lsu_wdata = 0; lsu_sel = 0; lsu_flush = 0;
        mem_ack = 0; mem_rdata = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vout_t zero_o, act_o;
        int    errs;
        logic  got;
        zero_o = '0;

        // Vectors, one per cycle, starting from IDLE with the streak cleared.
        tbl[0]  = '{mk_in(1, 32'h80, 0, 0, 0, 0, 0, 0, 0, 0, 0), zero_o};
        tbl[1]  = '{mk_in(1, 32'h80, 0, 0, 0, 0, 0, 0, 0, 0, 0),
                    mk_out(0, 0, 0, 0, 1, 0, 32'h80, 0, 4'hF, 0, 2'b01)};
        tbl[2]  = tbl[1];
        tbl[3]  = '{mk_in(1, 32'h80, 0, 0, 0, 0, 0, 0, 0, 1, 32'h13),
                    mk_out(1, 32'h13, 0, 0, 1, 0, 32'h80, 0, 4'hF, 0, 2'b01)};
        tbl[4]  = '{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), zero_o};
        tbl[5]  = '{mk_in(1, 32'h200, 0, 1, 1, 32'h100, 32'hDEAD, 4'b0011, 0, 0, 0), zero_o};
        tbl[6]  = '{mk_in(1, 32'h200, 0, 1, 1, 32'h100, 32'hDEAD, 4'b0011, 0, 0, 0),
                    mk_out(0, 0, 0, 0, 1, 1, 32'h100, 32'hDEAD, 4'b0011, 0, 2'b10)};
        tbl[7]  = '{mk_in(1, 32'h200, 0, 1, 1, 32'h100, 32'hDEAD, 4'b0011, 0, 1, 32'h55),
                    mk_out(0, 0, 1, 32'h55, 1, 1, 32'h100, 32'hDEAD, 4'b0011, 0, 2'b10)};
        tbl[8]  = '{mk_in(1, 32'h200, 0, 0, 0, 0, 0, 0, 0, 0, 0), zero_o};
        tbl[9]  = '{mk_in(1, 32'h200, 0, 0, 0, 0, 0, 0, 0, 0, 0),
                    mk_out(0, 0, 0, 0, 1, 0, 32'h200, 0, 4'hF, 0, 2'b01)};
        tbl[10] = '{mk_in(1, 32'h200, 0, 0, 0, 0, 0, 0, 0, 1, 32'hABCD),
                    mk_out(1, 32'hABCD, 0, 0, 1, 0, 32'h200, 0, 4'hF, 0, 2'b01)};
        tbl[11] = '{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h77), zero_o};
        tbl[12] = '{mk_in(1, 32'h300, 1, 0, 0, 0, 0, 0, 0, 0, 0), zero_o};
        tbl[13] = '{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), zero_o};
        tbl[14] = '{mk_in(0, 0, 0, 1, 0, 32'h340, 0, 4'hF, 1, 0, 0), zero_o};
        tbl[15] = '{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), zero_o};

        clear_inputs();
        rst_n = 0;
        #3;
        act_o = sample();
        checks++;
        if (act_o !== zero_o) begin
            failures++;
            $display("FAIL reset_state: got %h expected %h", act_o, zero_o);
        end
        @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            {if_req, if_addr, if_flush, lsu_req, lsu_w_en, lsu_addr, lsu_wdata,
             lsu_sel, lsu_flush, mem_ack, mem_rdata} = tbl[i].vi;
            #1;
            act_o = sample();
            checks++;
            if (act_o !== tbl[i].vo) begin
                failures++;
                $display("FAIL vec%0d: got %h expected %h", i, act_o, tbl[i].vo);
            end
        end

        // Starvation: both held, four LSU grants then IF.
        @(negedge clk);
        clear_inputs();
        if_req = 1; if_addr = 32'h400;
        lsu_req = 1; lsu_addr = 32'h300; lsu_sel = 4'hF;
        for (int g = 0; g < 5; g++) begin
            got = 0;
            for (int c = 0; c < 10 && !got; c++) begin
                @(negedge clk);
                #1;
                if (grant_o != 2'b00) got = 1;
            end
            check($sformatf("starve_grant%0d", g), 64'(grant_o), (g < 4) ? 64'h2 : 64'h1);
            mem_ack = 1; mem_rdata = 32'(g + 1);
            #1;
            check($sformatf("starve_ack%0d", g), {62'b0, if_ack_o, lsu_ack_o},
                  (g < 4) ? 64'h1 : 64'h2);
            @(negedge clk);
            mem_ack = 0; mem_rdata = 0;
        end
        if_req = 0; lsu_req = 0;
        #1;
        check("starve_idle", 64'(grant_o), 64'h0);

        // LSU flush one cycle after grant, ack three cycles later.
        @(negedge clk);
        lsu_req = 1; lsu_addr = 32'h500; lsu_sel = 4'hF;
        @(negedge clk); #1;
        check("flush_grant", 64'(grant_o), 64'h2);
        @(negedge clk);
        lsu_flush = 1; lsu_req = 0;
        #1;
        check("flush_req_held", {62'b0, mem_req_o, lsu_ack_o}, 64'h2);
        @(negedge clk);
        lsu_flush = 0;
        #1;
        check("flush_req_held2", 64'(mem_req_o), 64'h1);
        @(negedge clk);
        @(negedge clk);
        mem_ack = 1; mem_rdata = 32'h11;
        #1;
        check("flush_ack_suppressed", {mem_req_o, lsu_ack_o, lsu_rdata_o}, {1'b1, 1'b0, 32'h0});
        @(negedge clk);
        mem_ack = 0; mem_rdata = 0;
        #1;
        check("flush_idle", {61'b0, mem_req_o, grant_o}, 64'h0);

        // IF flush in the same cycle as the memory ack.
        @(negedge clk);
        if_req = 1; if_addr = 32'h800;
        @(negedge clk); #1;
        check("flush_ack_same_grant", 64'(grant_o), 64'h1);
        @(negedge clk);
        if_flush = 1; if_req = 0; mem_ack = 1; mem_rdata = 32'h22;
        #1;
        check("flush_ack_same", {if_ack_o, if_rdata_o}, 64'h0);
        @(negedge clk);
        if_flush = 0; mem_ack = 0; mem_rdata = 0;
        #1;
        check("flush_ack_same_idle", {61'b0, mem_req_o, grant_o}, 64'h0);

        // Timeout after 8 busy cycles without ack.
        @(negedge clk);
        if_req = 1; if_addr = 32'h600; mem_rdata = 32'hFFFF;
        errs = 0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk); #1;
            if (bus_err_o || if_ack_o || !mem_req_o) errs++;
        end
        check("tmo_early", 64'(errs), 64'h0);
        @(negedge clk); #1;
        check("tmo_hit", {bus_err_o, if_ack_o, if_rdata_o, mem_req_o}, {1'b1, 1'b1, 32'h0, 1'b1});
        @(negedge clk);
        if_req = 0;
        #1;
        check("tmo_after", {60'b0, mem_req_o, bus_err_o, grant_o}, 64'h0);

        // Ack on the 8th busy cycle wins over the timeout.
        @(negedge clk);
        if_req = 1; if_addr = 32'h640; mem_rdata = 0;
        for (int k = 1; k <= 7; k++) @(negedge clk);
        @(negedge clk);
        mem_ack = 1; mem_rdata = 32'h99;
        #1;
        check("tmo_ack_wins", {bus_err_o, if_ack_o, if_rdata_o}, {1'b0, 1'b1, 32'h99});
        @(negedge clk);
        mem_ack = 0; mem_rdata = 0; if_req = 0;
        #1;
        check("tmo_ack_idle", 64'(mem_req_o), 64'h0);

        // Reset in the middle of an LSU transaction.
        @(negedge clk);
        lsu_req = 1; lsu_w_en = 1; lsu_addr = 32'h900; lsu_wdata = 32'h1234; lsu_sel = 4'hF;
        @(negedge clk); #1;
        check("rst_pre_grant", {mem_req_o, grant_o, mem_addr_o}, {1'b1, 2'b10, 32'h900});
        #2;
        rst_n = 0;
        #1;
        act_o = sample();
        checks++;
        if (act_o !== zero_o) begin
            failures++;
            $display("FAIL rst_mid: got %h expected %h", act_o, zero_o);
        end
        clear_inputs();
        @(negedge clk);
        rst_n = 1;
        if_req = 1; if_addr = 32'hA00;
        @(negedge clk); #1;
        check("rst_post_grant", {mem_req_o, grant_o, mem_addr_o, mem_sel_o},
              {1'b1, 2'b01, 32'hA00, 4'hF});
        mem_ack = 1; mem_rdata = 32'h5A;
        #1;
        check("rst_post_ack", {if_ack_o, if_rdata_o, lsu_ack_o}, {1'b1, 32'h5A, 1'b0});
        @(negedge clk);
        clear_inputs();
        #1;
        check("rst_post_idle", {61'b0, mem_req_o, grant_o}, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Shares the single core-side memory port between the instruction fetch unit (IF) and the load/store unit (LSU).
- Fixed priority goes to the LSU, bounded by an anti-starvation counter for IF.
- Sequences exactly one outstanding transaction at a time, with flush-tolerant acknowledge routing and a bus timeout.
- Sits between the IF/LSU stages and the memory interconnect. Its LSU-side ack is the one consumed by the pipeline stall logic.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte-select width is DATA_W/8.
- STARVE_LIMIT, 4, maximum consecutive LSU grants while IF is pending (1..15).
- TIMEOUT_CYC, 255, busy cycles before forced termination; 0 disables the timeout (counter width 8).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- if_req_i  in  1  IF request; level, held until if_ack_o or flush
- if_addr_i  in  ADDR_W  IF address
- if_flush_i  in  1  IF flush (PC redirect)
- if_ack_o  out  1  IF transaction done
- if_rdata_o  out  DATA_W  IF read data, valid with if_ack_o
- lsu_req_i  in  1  LSU request; level
- lsu_w_en_i  in  1  1 = write
- lsu_addr_i  in  ADDR_W  LSU address
- lsu_wdata_i  in  DATA_W  write data
- lsu_sel_i  in  DATA_W/8  byte selects
- lsu_flush_i  in  1  LSU flush (CSR redirect / WFI)
- lsu_ack_o  out  1  LSU transaction done
- lsu_rdata_o  out  DATA_W  LSU read data, valid with lsu_ack_o
- mem_req_o  out  1  shared-port request
- mem_w_en_o  out  1  shared-port write enable
- mem_addr_o  out  ADDR_W  shared-port address
- mem_wdata_o  out  DATA_W  shared-port write data
- mem_sel_o  out  DATA_W/8  shared-port byte selects; all ones for IF
- mem_ack_i  in  1  shared-port done
- mem_rdata_i  in  DATA_W  shared-port read data
- bus_err_o  out  1  one-cycle pulse on timeout
- grant_o  out  2  current owner: 00 none, 01 IF, 10 LSU

Behaviour:
- Reset (async): state IDLE; all mem_* outputs, acks, rdata, bus_err_o and grant_o are 0; streak, timeout and drop flags cleared. Reset mid-transaction abandons the transaction; mem_req_o drops immediately.
- States: IDLE, IF_BUSY, LSU_BUSY. All mem_* outputs are registered and captured on the grant edge.
- IDLE arbitration, evaluated each cycle:
  - A requester is eligible when its req=1 and its flush=0.
  - LSU wins if eligible, unless IF is eligible and streak==STARVE_LIMIT, in which case IF wins.
- Grant timing: request seen in cycle N gives mem_req_o=1 and updated grant_o in N+1. The busy state holds mem_* stable until mem_ack_i.
- Completion: mem_ack_i=1 in a busy state in cycle M.
  - The owner's ack_o=1 and rdata_o=mem_rdata_i combinationally in cycle M; rdata_o is 0 otherwise.
  - mem_req_o=0 and state=IDLE from M+1.
  - Minimum one IDLE cycle between transactions.
- Streak counter:
  - +1 on an LSU grant while IF is eligible, saturating at STARVE_LIMIT.
  - Cleared on any IF grant, and on any cycle IF is not eligible.
- Flush during a busy state for that owner: set the drop flag, keep mem_req_o asserted until mem_ack_i, suppress the owner's ack, then go to IDLE. Flush of the non-owner has no effect on the current transaction. Flush and mem_ack_i in the same cycle: ack is suppressed.
- Timeout (TIMEOUT_CYC>0): the counter clears on grant and increments each busy cycle without mem_ack_i. On reaching TIMEOUT_CYC:
  - the owner gets ack_o=1 with rdata_o=0 (unless drop is set);
  - bus_err_o pulses for 1 cycle;
  - mem_req_o=0 next cycle; state goes to IDLE.
  - If mem_ack_i arrives in the same cycle, it takes precedence and there is no error.
- mem_ack_i in IDLE is ignored.
- Only one ack_o is ever high per cycle.

Test Plan:
- IF only: if_addr=0x80 at cycle 0, mem_ack at cycle 3 with rdata 0x13 -> mem_req_o cycles 1-3, if_ack_o=1 and if_rdata_o=0x13 at cycle 3, grant_o 01→00 at cycle 4.
- Simultaneous if_req/lsu_req (write 0xDEAD to 0x100, sel 0011) -> LSU granted first with mem_w_en_o=1 and mem_sel_o=0011; IF granted after the LSU ack plus 1 IDLE cycle.
- Starvation: lsu_req held continuously with if_req high, STARVE_LIMIT=4 -> four LSU grants, then IF is granted on the fifth arbitration.
- lsu_flush_i asserted 1 cycle after an LSU grant, mem_ack 3 cycles later -> mem_req_o held until ack, lsu_ack_o never asserted, state IDLE next.
- Timeout: TIMEOUT_CYC=8, no mem_ack_i -> owner ack with rdata 0 and bus_err_o pulse at the 8th busy cycle; mem_req_o=0 the following cycle.
- rst_n low mid LSU_BUSY -> all outputs 0 immediately; after release, a fresh IF request is granted normally.
